// File: rtl/trachtenberg_rr_sched.sv
// trachtenberg_rr_sched
// Round-robin front end that shares one external multiplier core among
// NREQ requesters. One operation is in flight at a time:
// IDLE (select) -> ISSUE (start core) -> WAIT (MUL_LAT cycles) -> DONE (return).
//
// Ports
//   iclk      clock, rising edge
//   irst      synchronous active-high reset
//   ireq      per-requester request, held until ogrant
//   ia, ib    packed operands, requester k at [k*WIDTH +: WIDTH]
//   ogrant    one-hot pulse: operands of requester k taken (ISSUE cycle)
//   ovalid    one-hot pulse: ores belongs to requester k (DONE cycle)
//   ores      product, held until the next capture
//   obusy     high whenever the scheduler is not in IDLE
//   ocount    completed-operation counter, wraps
//   om_start  one-cycle start to the multiplier core
//   om_a/om_b operands to the core, held until the next issue
//   im_res    product from the core
module trachtenberg_rr_sched #(
  parameter int WIDTH   = 5,
  parameter int NREQ    = 4,
  parameter int MUL_LAT = 2,
  parameter int CNT_W   = 8
) (
  input  logic                    iclk,
  input  logic                    irst,
  input  logic [NREQ-1:0]         ireq,
  input  logic [NREQ*WIDTH-1:0]   ia,
  input  logic [NREQ*WIDTH-1:0]   ib,
  output logic [NREQ-1:0]         ogrant,
  output logic [NREQ-1:0]         ovalid,
  output logic [2*WIDTH-1:0]      ores,
  output logic                    obusy,
  output logic [CNT_W-1:0]        ocount,
  output logic                    om_start,
  output logic [WIDTH-1:0]        om_a,
  output logic [WIDTH-1:0]        om_b,
  input  logic [2*WIDTH-1:0]      im_res
);

  localparam int IDX_W = (NREQ <= 2) ? 1 : $clog2(NREQ);
  localparam int LAT_W = (MUL_LAT <= 2) ? 1 : $clog2(MUL_LAT);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]       state_r;
  logic [IDX_W-1:0] ptr_r;
  logic [IDX_W-1:0] idx_r;
  logic [LAT_W-1:0] lat_r;

  logic             any_s;
  logic [IDX_W-1:0] sel_s;
  logic [IDX_W-1:0] nxt_ptr_s;

  function automatic logic [NREQ-1:0] onehot(input logic [IDX_W-1:0] k);
    onehot = {{(NREQ-1){1'b0}}, 1'b1} << k;
  endfunction

  // Rotating priority search: first set request at ptr, ptr+1, ... mod NREQ.
  always_comb begin : sel_p
    int j;
    any_s = 1'b0;
    sel_s = {IDX_W{1'b0}};
    for (int i = 0; i < NREQ; i++) begin
      j = (int'(ptr_r) + i) % NREQ;
      if (!any_s && ireq[j]) begin
        any_s = 1'b1;
        sel_s = IDX_W'(j);
      end else begin
        sel_s = sel_s;
      end
    end
  end

  // Pointer moves to the requester after the one just served.
  always_comb begin
    if (idx_r == IDX_W'(NREQ - 1)) begin
      nxt_ptr_s = {IDX_W{1'b0}};
    end else begin
      nxt_ptr_s = idx_r + 1'b1;
    end
  end

  // Scheduler FSM; all outputs are registered and change with the state.
  always_ff @(posedge iclk) begin
    if (irst) begin
      state_r  <= ST_IDLE;
      ptr_r    <= {IDX_W{1'b0}};
      idx_r    <= {IDX_W{1'b0}};
      lat_r    <= {LAT_W{1'b0}};
      ogrant   <= {NREQ{1'b0}};
      ovalid   <= {NREQ{1'b0}};
      ores     <= {(2*WIDTH){1'b0}};
      obusy    <= 1'b0;
      ocount   <= {CNT_W{1'b0}};
      om_start <= 1'b0;
      om_a     <= {WIDTH{1'b0}};
      om_b     <= {WIDTH{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (any_s) begin
            idx_r    <= sel_s;
            om_a     <= ia[sel_s*WIDTH +: WIDTH];
            om_b     <= ib[sel_s*WIDTH +: WIDTH];
            om_start <= 1'b1;
            ogrant   <= onehot(sel_s);
            obusy    <= 1'b1;
            state_r  <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          om_start <= 1'b0;
          ogrant   <= {NREQ{1'b0}};
          lat_r    <= LAT_W'(MUL_LAT - 1);
          state_r  <= ST_WAIT;
        end
        ST_WAIT: begin
          // Counter hits zero in the cycle the core result becomes stable.
          if (lat_r == {LAT_W{1'b0}}) begin
            ores    <= im_res;
            ovalid  <= onehot(idx_r);
            ocount  <= ocount + {{(CNT_W-1){1'b0}}, 1'b1};
            ptr_r   <= nxt_ptr_s;
            state_r <= ST_DONE;
          end else begin
            lat_r <= lat_r - 1'b1;
          end
        end
        ST_DONE: begin
          ovalid  <= {NREQ{1'b0}};
          obusy   <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          ogrant   <= {NREQ{1'b0}};
          ovalid   <= {NREQ{1'b0}};
          om_start <= 1'b0;
          obusy    <= 1'b0;
          state_r  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
